// File: rtl/move_receiver.sv
// Per-square move receiver: snapshots the 8 ray and 8 knight channels, scans them in order,
// emits one candidate move per legal arrival over valid/ready, and forwards sliding rays one hop.
module move_receiver #(
  parameter logic WHITE  = 1'b1,
  parameter int   FWD_EN = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        engine_color,
  input  logic [5:0]  my_piece,
  input  logic [5:0]  my_pos,
  input  logic        start,
  input  logic [10:0] U_in,
  input  logic [10:0] D_in,
  input  logic [10:0] L_in,
  input  logic [10:0] R_in,
  input  logic [10:0] UL_in,
  input  logic [10:0] UR_in,
  input  logic [10:0] DL_in,
  input  logic [10:0] DR_in,
  input  logic [7:0]  UUL_in,
  input  logic [7:0]  UUR_in,
  input  logic [7:0]  LLU_in,
  input  logic [7:0]  RRU_in,
  input  logic [7:0]  DDL_in,
  input  logic [7:0]  DDR_in,
  input  logic [7:0]  LLD_in,
  input  logic [7:0]  RRD_in,
  output logic [10:0] U_fwd,
  output logic [10:0] D_fwd,
  output logic [10:0] L_fwd,
  output logic [10:0] R_fwd,
  output logic [10:0] UL_fwd,
  output logic [10:0] UR_fwd,
  output logic [10:0] DL_fwd,
  output logic [10:0] DR_fwd,
  output logic        move_valid,
  input  logic        move_ready,
  output logic [5:0]  move_from,
  output logic [5:0]  move_to,
  output logic [5:0]  move_piece,
  output logic        move_capture,
  output logic        done
);

  localparam logic [3:0] T_PAWN   = 4'b0001;
  localparam logic [3:0] T_KING   = 4'b0010;
  localparam logic [3:0] T_BISHOP = 4'b0100;
  localparam logic [3:0] T_ROOK   = 4'b1000;
  localparam logic [3:0] T_QUEEN  = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_DONE} state_t;

  state_t      state;
  logic [3:0]  idx;
  logic [10:0] ray_in   [8];
  logic [10:0] ray_fwd  [8];
  logic [7:0]  hop_in   [8];
  logic [10:0] snap_ray [8];
  logic [7:0]  snap_hop [8];
  logic [5:0]  snap_piece;
  logic [5:0]  snap_pos;

  logic        eval_legal;
  logic        eval_capture;
  logic [5:0]  eval_from;
  logic [5:0]  eval_piece;
  logic [10:0] eval_ray;
  logic [7:0]  eval_hop;
  logic        tgt_empty;
  logic        tgt_enemy;

  assign ray_in = '{U_in, D_in, L_in, R_in, UL_in, UR_in, DL_in, DR_in};
  assign hop_in = '{UUL_in, UUR_in, LLU_in, RRU_in, DDL_in, DDR_in, LLD_in, RRD_in};

  assign U_fwd  = ray_fwd[0];
  assign D_fwd  = ray_fwd[1];
  assign L_fwd  = ray_fwd[2];
  assign R_fwd  = ray_fwd[3];
  assign UL_fwd = ray_fwd[4];
  assign UR_fwd = ray_fwd[5];
  assign DL_fwd = ray_fwd[6];
  assign DR_fwd = ray_fwd[7];

  // Colours are compared by side, so the WHITE encoding remains the single source of truth.
  function automatic logic same_side(input logic a, input logic b);
    return (a == WHITE) == (b == WHITE);
  endfunction

  function automatic logic is_sliding(input logic [3:0] t);
    return (t == T_ROOK) || (t == T_QUEEN) || (t == T_BISHOP);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) ray_fwd[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++)
        ray_fwd[i] <= (FWD_EN != 0 && my_piece[4:0] == 5'd0 && is_sliding(ray_in[i][9:6]))
                      ? ray_in[i] : 11'd0;
    end
  end

  // NOTE: snapshot storage has no reset; it is only read after a start has loaded it.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      snap_ray   <= ray_in;
      snap_hop   <= hop_in;
      snap_piece <= my_piece;
      snap_pos   <= my_pos;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    eval_legal   = 1'b0;
    eval_capture = 1'b0;
    eval_from    = 6'd0;
    eval_piece   = 6'd0;
    eval_ray     = snap_ray[idx[2:0]];
    eval_hop     = snap_hop[idx[2:0]];
    tgt_empty    = (snap_piece[4:0] == 5'd0);
    tgt_enemy    = !tgt_empty && !same_side(snap_piece[5], engine_color);
    if (!idx[3]) begin
      eval_from  = eval_ray[5:0];
      eval_piece = {eval_ray[10:6], 1'b0};
      if (same_side(eval_ray[10], engine_color)) begin
        case (eval_ray[9:6])
          T_PAWN: begin
            // Diagonals capture only; straight pushes along U/D need an empty square.
            if (idx[2]) begin
              eval_legal   = tgt_enemy;
              eval_capture = 1'b1;
            end else if (idx[2:1] == 2'b00) begin
              eval_legal = tgt_empty;
            end
          end
          T_ROOK, T_QUEEN, T_BISHOP, T_KING: begin
            eval_legal   = tgt_empty || tgt_enemy;
            eval_capture = tgt_enemy;
          end
          default: ;
        endcase
      end
    end else begin
      eval_from  = eval_hop[5:0];
      eval_piece = {eval_hop[7], 4'b0000, 1'b1};
      if (eval_hop[6] && same_side(eval_hop[7], engine_color)) begin
        eval_legal   = tgt_empty || tgt_enemy;
        eval_capture = tgt_enemy;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      idx          <= 4'd0;
      move_valid   <= 1'b0;
      move_from    <= 6'd0;
      move_to      <= 6'd0;
      move_piece   <= 6'd0;
      move_capture <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx   <= 4'd0;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (eval_legal) begin
            move_valid   <= 1'b1;
            move_from    <= eval_from;
            move_to      <= snap_pos;
            move_piece   <= eval_piece;
            move_capture <= eval_capture;
            state        <= S_EMIT;
          end else if (idx == 4'd15) begin
            state <= S_DONE;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        S_EMIT: begin
          if (move_ready) begin
            move_valid <= 1'b0;
            if (idx == 4'd15) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 4'd1;
              state <= S_SCAN;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_receiver.sv
// Directed bench for move_receiver: expected move records are queued as stimulus is set up
// and compared as the DUT presents them, with done timing derived from the record count.
module tb_move_receiver;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        engine_color, start, move_ready;
  logic [5:0]  my_piece, my_pos;
  logic [10:0] U_in, D_in, L_in, R_in, UL_in, UR_in, DL_in, DR_in;
  logic [7:0]  UUL_in, UUR_in, LLU_in, RRU_in, DDL_in, DDR_in, LLD_in, RRD_in;
  logic [10:0] U_fwd, D_fwd, L_fwd, R_fwd, UL_fwd, UR_fwd, DL_fwd, DR_fwd;
  logic        move_valid, move_capture, done;
  logic [5:0]  move_from, move_to, move_piece;

  typedef struct packed {
    logic [5:0] from;
    logic [5:0] to;
    logic [5:0] piece;
    logic       capture;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  move_receiver dut (
    .clk(clk), .reset_n(reset_n), .engine_color(engine_color),
    .my_piece(my_piece), .my_pos(my_pos), .start(start),
    .U_in(U_in), .D_in(D_in), .L_in(L_in), .R_in(R_in),
    .UL_in(UL_in), .UR_in(UR_in), .DL_in(DL_in), .DR_in(DR_in),
    .UUL_in(UUL_in), .UUR_in(UUR_in), .LLU_in(LLU_in), .RRU_in(RRU_in),
    .DDL_in(DDL_in), .DDR_in(DDR_in), .LLD_in(LLD_in), .RRD_in(RRD_in),
    .U_fwd(U_fwd), .D_fwd(D_fwd), .L_fwd(L_fwd), .R_fwd(R_fwd),
    .UL_fwd(UL_fwd), .UR_fwd(UR_fwd), .DL_fwd(DL_fwd), .DR_fwd(DR_fwd),
    .move_valid(move_valid), .move_ready(move_ready),
    .move_from(move_from), .move_to(move_to), .move_piece(move_piece),
    .move_capture(move_capture), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_channels();
    {U_in, D_in, L_in, R_in, UL_in, UR_in, DL_in, DR_in} = '0;
    {UUL_in, UUR_in, LLU_in, RRU_in, DDL_in, DDR_in, LLD_in, RRD_in} = '0;
  endtask

  // Pulses start, then watches a bounded window: pops a queued record whenever a new one
  // appears, holds ready low for 'stall' cycles per record, and checks done timing/count.
  task automatic run_scan(input string tag, input int stall, input bit mid_start,
                          input bit clear_after);
    int   n_exp, exp_done, first_done, n_done, stall_left;
    bit   holding;
    rec_t cur, got;
    n_exp      = exp_q.size();
    exp_done   = 17 + n_exp * (1 + stall);
    first_done = -1;
    n_done     = 0;
    stall_left = 0;
    holding    = 1'b0;
    cur        = '0;
    @(negedge clk);
    start      = 1'b1;
    move_ready = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (clear_after) clear_channels();
    for (int cyc = 1; cyc <= exp_done + 4; cyc++) begin
      @(posedge clk);
      #1;
      start = mid_start && (cyc == 3);
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = cyc;
      end
      if (move_valid) begin
        got = '{move_from, move_to, move_piece, move_capture};
        if (!holding) begin
          if (exp_q.size() == 0) begin
            check({tag, " extra_record"}, move_valid, 1'b0);
          end else begin
            cur = exp_q.pop_front();
            check({tag, " from"}, move_from, cur.from);
            check({tag, " to"}, move_to, cur.to);
            check({tag, " piece"}, move_piece, cur.piece);
            check({tag, " capture"}, move_capture, cur.capture);
          end
          holding    = 1'b1;
          stall_left = stall;
        end else begin
          check({tag, " held_record"}, got, cur);
        end
        if (stall_left > 0) begin
          move_ready = 1'b0;
          stall_left--;
        end else begin
          move_ready = 1'b1;
          holding    = 1'b0;
        end
      end else begin
        move_ready = 1'b0;
      end
    end
    move_ready = 1'b0;
    check({tag, " done_count"}, n_done, 1);
    check({tag, " done_cycle"}, first_done, exp_done);
    check({tag, " records_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    clear_channels();
    start        = 1'b0;
    move_ready   = 1'b0;
    engine_color = 1'b1;
    my_piece     = 6'd0;
    my_pos       = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset move_valid", move_valid, 1'b0);
    check("reset done", done, 1'b0);
    check("reset move_rec", {move_from, move_to, move_piece, move_capture}, 19'd0);
    check("reset fwd", {U_fwd, L_fwd, DR_fwd}, 33'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Rook ray into an empty square, plus one-hop forwarding.
    @(negedge clk);
    my_pos = 6'd20;
    L_in   = 11'b1_1000_000011;
    @(posedge clk);
    #1;
    check("rook L_fwd", L_fwd, 11'b1_1000_000011);
    check("rook U_fwd", U_fwd, 11'd0);
    exp_q.push_back('{6'd3, 6'd20, 6'b110000, 1'b0});
    run_scan("rook", 0, 1'b0, 1'b0);

    // White pawn vs black knight target: straight push blocked, diagonal captures.
    @(negedge clk);
    clear_channels();
    my_piece = 6'b000001;
    my_pos   = 6'd9;
    U_in     = 11'b1_0001_001100;
    @(posedge clk);
    #1;
    check("pawn_u U_fwd", U_fwd, 11'd0);
    run_scan("pawn_u", 0, 1'b0, 1'b0);
    @(negedge clk);
    clear_channels();
    UL_in = 11'b1_0001_001100;
    exp_q.push_back('{6'd12, 6'd9, 6'b100010, 1'b1});
    run_scan("pawn_ul", 0, 1'b0, 1'b0);
    check("pawn_ul UL_fwd", UL_fwd, 11'd0);

    // Knight packet: own-piece target blocks it, empty target accepts it.
    @(negedge clk);
    clear_channels();
    my_piece = 6'b110000;
    my_pos   = 6'd30;
    UUR_in   = 8'b1_1_010000;
    run_scan("knight_own", 0, 1'b0, 1'b0);
    @(negedge clk);
    my_piece = 6'd0;
    exp_q.push_back('{6'd16, 6'd30, 6'b100001, 1'b0});
    run_scan("knight_empty", 0, 1'b0, 1'b0);

    // Backpressure on two records, with a stray start pulse mid-scan.
    @(negedge clk);
    clear_channels();
    my_piece = 6'd0;
    my_pos   = 6'd45;
    U_in     = 11'b1_1000_000100;
    DR_in    = 11'b1_0100_000101;
    @(posedge clk);
    #1;
    check("bp DR_fwd", DR_fwd, 11'b1_0100_000101);
    exp_q.push_back('{6'd4, 6'd45, 6'b110000, 1'b0});
    exp_q.push_back('{6'd5, 6'd45, 6'b101000, 1'b0});
    run_scan("backpressure", 5, 1'b1, 1'b0);

    // Mixed channels on an enemy target; inputs cleared right after the snapshot edge.
    @(negedge clk);
    clear_channels();
    my_piece = 6'b000011;
    my_pos   = 6'd27;
    D_in     = 11'b1_1100_100011;
    L_in     = 11'b0_1000_011010;
    R_in     = 11'b1_0110_011100;
    UR_in    = 11'b1_0001_010011;
    DL_in    = 11'b1_0010_100010;
    LLD_in   = 8'b1_0_010001;
    RRD_in   = 8'b1_1_010101;
    @(posedge clk);
    #1;
    check("mixed D_fwd", D_fwd, 11'd0);
    exp_q.push_back('{6'd35, 6'd27, 6'b111000, 1'b1});
    exp_q.push_back('{6'd19, 6'd27, 6'b100010, 1'b1});
    exp_q.push_back('{6'd34, 6'd27, 6'b100100, 1'b1});
    exp_q.push_back('{6'd21, 6'd27, 6'b100001, 1'b1});
    run_scan("mixed", 0, 1'b0, 1'b1);

    // Black to move: black knight captures white piece, black pawn push is blocked.
    @(negedge clk);
    clear_channels();
    engine_color = 1'b0;
    my_piece     = 6'b100101;
    my_pos       = 6'd40;
    UUL_in       = 8'b0_1_000111;
    U_in         = 11'b0_0001_110000;
    exp_q.push_back('{6'd7, 6'd40, 6'b000001, 1'b1});
    run_scan("black", 0, 1'b0, 1'b0);

    // Asynchronous reset while a record is held in EMIT.
    @(negedge clk);
    clear_channels();
    engine_color = 1'b1;
    my_piece     = 6'd0;
    my_pos       = 6'd50;
    L_in         = 11'b1_1000_000011;
    start        = 1'b1;
    move_ready   = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 30 && !move_valid; k++) begin
      @(posedge clk);
      #1;
    end
    check("rst_emit valid_before", move_valid, 1'b1);
    check("rst_emit L_fwd_before", L_fwd, 11'b1_1000_000011);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_emit move_valid", move_valid, 1'b0);
    check("rst_emit L_fwd", L_fwd, 11'd0);
    check("rst_emit done", done, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back('{6'd3, 6'd50, 6'b110000, 1'b0});
    run_scan("after_reset", 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
